vend_session_arbiter: RTL and testbench

//  Shares one vending_mealy core (coin[1:0] in, dispense/chg5 out, price 20) among N_REQ coin inlets.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_rr_pick.sv | 30 +++
 rtl/vending_mealy.sv | 33 +++
 rtl/vend_session_arbiter.sv | 151 +++++++++++++++
 tb/tb_vend_session_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending core and the session arbiter in front of it.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int PRICE = 20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  // True for the two coin codes the core can actually take.
  function automatic logic coin_valid(input logic [1:0] c);
    return (c == COIN_5) || (c == COIN_10);
  endfunction

  // Monetary value of a coin code; the invalid code is worth nothing.
  function automatic logic [4:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module vend_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  // Walk the requesters starting at the pointer and keep only the first hit.
  always_comb begin
    int idx;
    idx     = 0;
    pick_o  = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vending_mealy.sv
// Single-inlet Mealy vending core: accumulates 5/10 credit and dispenses at PRICE,
// returning 5 in change when the last coin overshoots.
module vending_mealy
  import vend_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] coin_i,
  output logic       dispense_o,
  output logic       chg5_o
);

  logic [4:0] credit_q, credit_d;
  logic [4:0] total;

  // Outputs react to the coin in the same cycle; credit resets after a sale.
  always_comb begin
    total      = credit_q + coin_value(coin_i);
    dispense_o = (total >= 5'(PRICE));
    chg5_o     = (total == 5'(PRICE + 5));
    credit_d   = dispense_o ? 5'd0 : total;
  end

  // Credit register, cleared by the shared reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= 5'd0;
    end else begin
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one vending core among N_REQ coin inlets, one whole purchase session at a time,
// with round-robin ownership and an inactivity timeout that reclaims a stalled session.
module vend_session_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] coin_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [1:0]         vend_coin,
  input  logic               vend_dispense,
  input  logic               vend_chg5,
  output logic [N_REQ-1:0]   dispense_out,
  output logic [N_REQ-1:0]   chg5_out,
  output logic [N_REQ-1:0]   coin_rej,
  output logic               timeout_err,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rej_q, rej_d;
  logic [1:0]         vend_coin_q, vend_coin_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               tmo_q, tmo_d;

  logic [N_REQ-1:0]   pick;
  logic               pickValid;
  logic [1:0]         ownerCoin;
  logic [PW-1:0]      ptrAfterOwner;

  vend_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pickValid)
  );

  // Select the current owner's coin and the pointer slot just past the owner.
  always_comb begin
    ownerCoin     = COIN_NONE;
    ptrAfterOwner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        ownerCoin     = coin_in[2*i +: 2];
        ptrAfterOwner = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Session FSM: grant, coin forwarding, release on sale or inactivity, reject pulses.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    vend_coin_d = COIN_NONE;
    timer_d     = timer_q;
    ptr_d       = ptr_q;
    rej_d       = '0;
    tmo_d       = 1'b0;

    for (int i = 0; i < N_REQ; i++) begin
      if ((coin_in[2*i +: 2] != COIN_NONE) && !((state_q == ST_OWNED) && gnt_q[i])) begin
        rej_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pickValid) begin
          gnt_d   = pick;
          state_d = ST_OWNED;
        end
      end

      ST_OWNED: begin
        if (vend_dispense) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          ptr_d   = ptrAfterOwner;
          timer_d = '0;
          if (ownerCoin != COIN_NONE) begin
            rej_d = rej_d | gnt_q;
          end
        end else if (coin_valid(ownerCoin)) begin
          vend_coin_d = ownerCoin;
          timer_d     = '0;
        end else begin
          if (ownerCoin == COIN_BAD) begin
            rej_d = rej_d | gnt_q;
          end
          if (timer_q == TW'(TIMEOUT - 1)) begin
            gnt_d   = '0;
            state_d = ST_IDLE;
            ptr_d   = ptrAfterOwner;
            timer_d = '0;
            tmo_d   = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any session in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rej_q       <= '0;
      vend_coin_q <= COIN_NONE;
      timer_q     <= '0;
      ptr_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rej_q       <= rej_d;
      vend_coin_q <= vend_coin_d;
      timer_q     <= timer_d;
      ptr_q       <= ptr_d;
      tmo_q       <= tmo_d;
    end
  end

  assign gnt          = gnt_q;
  assign vend_coin    = vend_coin_q;
  assign coin_rej     = rej_q;
  assign timeout_err  = tmo_q;
  assign busy         = |gnt_q;
  assign dispense_out = gnt_q & {N_REQ{vend_dispense}};
  assign chg5_out     = gnt_q & {N_REQ{vend_chg5}};

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for the session arbiter driving a vending core.
module tb_vend_session_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] coin_in;
  logic [N_REQ-1:0]   gnt;
  logic [1:0]         vend_coin;
  logic               vend_dispense;
  logic               vend_chg5;
  logic [N_REQ-1:0]   dispense_out;
  logic [N_REQ-1:0]   chg5_out;
  logic [N_REQ-1:0]   coin_rej;
  logic               timeout_err;
  logic               busy;

  int assertCount = 0;
  int failCount   = 0;

  vend_session_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .coin_in       (coin_in),
    .gnt           (gnt),
    .vend_coin     (vend_coin),
    .vend_dispense (vend_dispense),
    .vend_chg5     (vend_chg5),
    .dispense_out  (dispense_out),
    .chg5_out      (chg5_out),
    .coin_rej      (coin_rej),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  vending_mealy u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .coin_i     (vend_coin),
    .dispense_o (vend_dispense),
    .chg5_o     (vend_chg5)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [2*N_REQ-1:0] c);
    req     = r;
    coin_in = c;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; all drives and samples happen 1 ns after a rising edge.
  initial begin
    rst = 1'b1;
    applyStimulus(4'b1111, 8'b01_10_01_10);
    #6;
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_vend_coin", 32'(vend_coin), 32'h0);
    checkOutput("rst_coin_rej", 32'(coin_rej), 32'h0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'h0);
    #6;
    rst = 1'b0;
    applyStimulus(4'b0000, 8'h00);
    stepCycle();
    checkOutput("idle_busy", 32'(busy), 32'h0);

    $display("[TB] single-owner purchase 10+10");
    applyStimulus(4'b0001, 8'h00);
    stepCycle();
    checkOutput("t2_gnt", 32'(gnt), 32'h1);
    checkOutput("t2_busy", 32'(busy), 32'h1);
    applyStimulus(4'b0001, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0001, 8'h00);
    checkOutput("t2_vend1", 32'(vend_coin), 32'h2);
    checkOutput("t2_disp1", 32'(dispense_out), 32'h0);
    stepCycle();
    checkOutput("t2_vend_gap", 32'(vend_coin), 32'h0);
    applyStimulus(4'b0001, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0000, 8'h00);
    checkOutput("t2_vend2", 32'(vend_coin), 32'h2);
    checkOutput("t2_disp2", 32'(dispense_out), 32'h1);
    checkOutput("t2_chg2", 32'(chg5_out), 32'h0);
    stepCycle();
    checkOutput("t2_release", 32'(gnt), 32'h0);
    checkOutput("t2_no_tmo", 32'(timeout_err), 32'h0);

    rst = 1'b1;
    stepCycle();
    rst = 1'b0;

    $display("[TB] round-robin between inlets 0 and 2");
    applyStimulus(4'b0101, 8'h00);
    stepCycle();
    checkOutput("t3_first", 32'(gnt), 32'h1);
    applyStimulus(4'b0101, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0101, 8'h00);
    stepCycle();
    applyStimulus(4'b0101, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0101, 8'h00);
    checkOutput("t3_disp", 32'(dispense_out), 32'h1);
    stepCycle();
    checkOutput("t3_gap", 32'(gnt), 32'h0);
    stepCycle();
    checkOutput("t3_second", 32'(gnt), 32'h4);

    rst = 1'b1;
    #1;
    checkOutput("async_rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] rejected coins");
    applyStimulus(4'b0001, 8'h00);
    stepCycle();
    checkOutput("t4_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0001, 8'b00_00_01_00);
    stepCycle();
    checkOutput("t4_rej_other", 32'(coin_rej), 32'h2);
    checkOutput("t4_vend_a", 32'(vend_coin), 32'h0);
    applyStimulus(4'b0001, 8'b00_00_00_11);
    stepCycle();
    checkOutput("t4_rej_bad", 32'(coin_rej), 32'h1);
    checkOutput("t4_vend_b", 32'(vend_coin), 32'h0);
    applyStimulus(4'b0001, 8'h00);
    stepCycle();
    checkOutput("t4_rej_clear", 32'(coin_rej), 32'h0);

    $display("[TB] overpay 10+5+10 gives change");
    applyStimulus(4'b0001, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0001, 8'h00);
    checkOutput("t5_vend1", 32'(vend_coin), 32'h2);
    stepCycle();
    applyStimulus(4'b0001, 8'b00_00_00_01);
    stepCycle();
    applyStimulus(4'b0001, 8'h00);
    checkOutput("t5_vend2", 32'(vend_coin), 32'h1);
    checkOutput("t5_disp2", 32'(dispense_out), 32'h0);
    stepCycle();
    applyStimulus(4'b0000, 8'b00_00_00_10);
    stepCycle();
    applyStimulus(4'b0000, 8'h00);
    checkOutput("t5_disp3", 32'(dispense_out), 32'h1);
    checkOutput("t5_chg3", 32'(chg5_out), 32'h1);
    stepCycle();
    checkOutput("t5_release", 32'(gnt), 32'h0);

    $display("[TB] inactivity timeout");
    applyStimulus(4'b0010, 8'h00);
    stepCycle();
    checkOutput("t6_gnt", 32'(gnt), 32'h2);
    applyStimulus(4'b0010, 8'b00_00_01_00);
    stepCycle();
    applyStimulus(4'b0010, 8'h00);
    checkOutput("t6_vend", 32'(vend_coin), 32'h1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      stepCycle();
    end
    checkOutput("t6_still_owned", 32'(gnt), 32'h2);
    checkOutput("t6_no_tmo_yet", 32'(timeout_err), 32'h0);
    stepCycle();
    checkOutput("t6_tmo_gnt", 32'(gnt), 32'h0);
    checkOutput("t6_tmo_pulse", 32'(timeout_err), 32'h1);
    applyStimulus(4'b0110, 8'h00);
    stepCycle();
    checkOutput("t6_tmo_end", 32'(timeout_err), 32'h0);
    checkOutput("t6_ptr_adv", 32'(gnt), 32'h4);
    applyStimulus(4'b0110, 8'b00_10_00_00);
    stepCycle();
    applyStimulus(4'b0110, 8'h00);
    checkOutput("t6_inherit_a", 32'(dispense_out), 32'h0);
    stepCycle();
    applyStimulus(4'b0110, 8'b00_01_00_00);
    stepCycle();
    applyStimulus(4'b0000, 8'h00);
    checkOutput("t6_inherit_b", 32'(dispense_out), 32'h4);

    rst = 1'b1;
    #1;
    checkOutput("final_rst_gnt", 32'(gnt), 32'h0);
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
